// File: rtl/nec_ir_pkg.sv
// rtl/nec_ir_pkg.sv - shared FSM state, timing windows and helpers for the NEC IR decoder
package nec_ir_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LEAD_MARK,
    LEAD_SPACE,
    BIT_MARK,
    BIT_SPACE,
    STOP_MARK,
    RPT_STOP
  } necState_t;

  localparam int NEC_BITS     = 32;
  localparam int TICK_NS      = 140625;
  localparam int TICK_DIVISOR = 1_000_000_000 / TICK_NS;

  // Inclusive tick windows, wide enough to absorb remote-to-remote carrier drift.
  localparam logic [7:0] LEAD_MARK_MIN  = 8'd56;
  localparam logic [7:0] LEAD_MARK_MAX  = 8'd72;
  localparam logic [7:0] FRAME_SPC_MIN  = 8'd28;
  localparam logic [7:0] FRAME_SPC_MAX  = 8'd36;
  localparam logic [7:0] RPT_SPC_MIN    = 8'd12;
  localparam logic [7:0] RPT_SPC_MAX    = 8'd20;
  localparam logic [7:0] BIT_MARK_MIN   = 8'd2;
  localparam logic [7:0] BIT_MARK_MAX   = 8'd6;
  localparam logic [7:0] ZERO_SPC_MIN   = 8'd2;
  localparam logic [7:0] ZERO_SPC_MAX   = 8'd6;
  localparam logic [7:0] ONE_SPC_MIN    = 8'd9;
  localparam logic [7:0] ONE_SPC_MAX    = 8'd15;

  function automatic logic inWindow(input logic [7:0] val, input logic [7:0] lo,
                                    input logic [7:0] hi);
    return (val >= lo) && (val <= hi);
  endfunction

endpackage

// File: rtl/nec_ir_rx_filter.sv
// rtl/nec_ir_rx_filter.sv - rxIN synchroniser and glitch filter producing a mark level and edge strobe
module nec_ir_rx_filter
  import nec_ir_pkg::*;
#(
  parameter int FILTER_CYCLES = 16,
  parameter int RX_ACTIVE_LOW = 1
) (
  input  logic clkIN,
  input  logic nResetIN,
  input  logic rxIN,
  output logic markOUT,
  output logic edgeOUT
);

  localparam logic IDLE_LEVEL = (RX_ACTIVE_LOW != 0);

  logic [1:0]  syncQ;
  logic        rawMark;
  logic [15:0] holdCnt;

  assign rawMark = (RX_ACTIVE_LOW != 0) ? ~syncQ[1] : syncQ[1];

  // A new level is accepted only after it has held for FILTER_CYCLES consecutive cycles.
  always_ff @(posedge clkIN or negedge nResetIN) begin
    if (!nResetIN) begin
      syncQ   <= {IDLE_LEVEL, IDLE_LEVEL};
      markOUT <= 1'b0;
      edgeOUT <= 1'b0;
      holdCnt <= '0;
    end else begin
      syncQ   <= {syncQ[0], rxIN};
      edgeOUT <= 1'b0;
      if (rawMark == markOUT) begin
        holdCnt <= '0;
      end else if (holdCnt == 16'(FILTER_CYCLES - 1)) begin
        markOUT <= rawMark;
        edgeOUT <= 1'b1;
        holdCnt <= '0;
      end else begin
        holdCnt <= holdCnt + 16'd1;
      end
    end
  end

endmodule

// File: rtl/nec_ir_decoder.sv
// rtl/nec_ir_decoder.sv - NEC IR frame/repeat decoder; `NEC_IR_STRICT_CHECK_EN enables inverse-byte integrity check
module nec_ir_decoder
  import nec_ir_pkg::*;
#(
  parameter int CLOCK_HZ      = 50_000_000,
  parameter int RX_ACTIVE_LOW = 1,
  parameter int FILTER_CYCLES = 16,
  parameter int EXTENDED_ADDR = 0,
  parameter int REPEAT_WINDOW = 800
) (
  input  logic        clkIN,
  input  logic        nResetIN,
  input  logic        rxIN,
  output logic        dataValidOUT,
  output logic        repeatOUT,
  output logic        errorOUT,
  output logic [31:0] dataOUT,
  output logic [15:0] addressOUT,
  output logic [7:0]  commandOUT,
  output logic [7:0]  repeatCountOUT
);

  localparam int TICK_DIV = (CLOCK_HZ / TICK_DIVISOR) > 0 ? (CLOCK_HZ / TICK_DIVISOR) : 1;

  logic                mark;
  logic                edgeStb;
  logic [23:0]         divCnt;
  logic [7:0]          durCnt;
  logic                tick;
  necState_t           state;
  logic [4:0]          bitIdx;
  logic [NEC_BITS-1:0] shiftReg;
  logic [15:0]         winCnt;
  logic                winOpen;
  logic                frameOk;
  logic                leaderOk, frameSpcOk, rptSpcOk, bitMarkOk, zeroOk, oneOk;

  nec_ir_rx_filter #(
    .FILTER_CYCLES(FILTER_CYCLES),
    .RX_ACTIVE_LOW(RX_ACTIVE_LOW)
  ) rxFilter (
    .clkIN   (clkIN),
    .nResetIN(nResetIN),
    .rxIN    (rxIN),
    .markOUT (mark),
    .edgeOUT (edgeStb)
  );

  assign tick       = (divCnt == 24'(TICK_DIV - 1));
  assign leaderOk   = inWindow(durCnt, LEAD_MARK_MIN, LEAD_MARK_MAX);
  assign frameSpcOk = inWindow(durCnt, FRAME_SPC_MIN, FRAME_SPC_MAX);
  assign rptSpcOk   = inWindow(durCnt, RPT_SPC_MIN, RPT_SPC_MAX);
  assign bitMarkOk  = inWindow(durCnt, BIT_MARK_MIN, BIT_MARK_MAX);
  assign zeroOk     = inWindow(durCnt, ZERO_SPC_MIN, ZERO_SPC_MAX);
  assign oneOk      = inWindow(durCnt, ONE_SPC_MIN, ONE_SPC_MAX);

`ifdef NEC_IR_STRICT_CHECK_EN
  assign frameOk = (shiftReg[31:24] == ~shiftReg[23:16]) &&
                   ((EXTENDED_ADDR != 0) || (shiftReg[15:8] == ~shiftReg[7:0]));
`else
  assign frameOk = 1'b1;
`endif

  // Phase timer: both divider and duration restart at every accepted edge.
  always_ff @(posedge clkIN or negedge nResetIN) begin
    if (!nResetIN) begin
      divCnt <= '0;
      durCnt <= '0;
    end else if (edgeStb) begin
      divCnt <= '0;
      durCnt <= '0;
    end else begin
      divCnt <= tick ? 24'd0 : divCnt + 24'd1;
      if (tick && durCnt != 8'hFF) durCnt <= durCnt + 8'd1;
    end
  end

  always_ff @(posedge clkIN or negedge nResetIN) begin
    if (!nResetIN) begin
      state          <= IDLE;
      bitIdx         <= '0;
      shiftReg       <= '0;
      winCnt         <= '0;
      winOpen        <= 1'b0;
      dataValidOUT   <= 1'b0;
      repeatOUT      <= 1'b0;
      errorOUT       <= 1'b0;
      dataOUT        <= '0;
      addressOUT     <= '0;
      commandOUT     <= '0;
      repeatCountOUT <= '0;
    end else begin
      dataValidOUT <= 1'b0;
      repeatOUT    <= 1'b0;
      errorOUT     <= 1'b0;
      if (tick && winOpen) begin
        if (winCnt == 16'(REPEAT_WINDOW - 1)) winOpen <= 1'b0;
        else winCnt <= winCnt + 16'd1;
      end
      if (edgeStb) begin
        // A leader-length mark ending in any later phase restarts decoding at its space.
        case (state)
          IDLE: if (mark) state <= LEAD_MARK;
          LEAD_MARK: begin
            if (leaderOk) state <= LEAD_SPACE;
            else begin errorOUT <= 1'b1; state <= IDLE; end
          end
          LEAD_SPACE: begin
            if (frameSpcOk) begin
              state  <= BIT_MARK;
              bitIdx <= '0;
            end else if (rptSpcOk) state <= RPT_STOP;
            else begin errorOUT <= 1'b1; state <= IDLE; end
          end
          BIT_MARK: begin
            if (leaderOk) begin errorOUT <= 1'b1; state <= LEAD_SPACE; end
            else if (bitMarkOk) state <= BIT_SPACE;
            else begin errorOUT <= 1'b1; state <= IDLE; end
          end
          BIT_SPACE: begin
            if (zeroOk || oneOk) begin
              shiftReg[bitIdx] <= oneOk;
              if (bitIdx == 5'(NEC_BITS - 1)) state <= STOP_MARK;
              else begin
                state  <= BIT_MARK;
                bitIdx <= bitIdx + 5'd1;
              end
            end else begin errorOUT <= 1'b1; state <= IDLE; end
          end
          STOP_MARK: begin
            if (leaderOk) begin errorOUT <= 1'b1; state <= LEAD_SPACE; end
            else if (bitMarkOk) begin
              state <= IDLE;
              if (frameOk) begin
                dataValidOUT   <= 1'b1;
                dataOUT        <= shiftReg;
                addressOUT     <= (EXTENDED_ADDR != 0) ? shiftReg[15:0] : {8'd0, shiftReg[7:0]};
                commandOUT     <= shiftReg[23:16];
                repeatCountOUT <= '0;
                winOpen        <= 1'b1;
                winCnt         <= '0;
              end else errorOUT <= 1'b1;
            end else begin errorOUT <= 1'b1; state <= IDLE; end
          end
          RPT_STOP: begin
            if (leaderOk) begin errorOUT <= 1'b1; state <= LEAD_SPACE; end
            else if (bitMarkOk) begin
              state <= IDLE;
              if (winOpen) begin
                repeatOUT <= 1'b1;
                if (repeatCountOUT != 8'hFF) repeatCountOUT <= repeatCountOUT + 8'd1;
                winOpen <= 1'b1;
                winCnt  <= '0;
              end else errorOUT <= 1'b1;
            end else begin errorOUT <= 1'b1; state <= IDLE; end
          end
          default: state <= IDLE;
        endcase
      end else if (state != IDLE && durCnt == 8'hFF) begin
        errorOUT <= 1'b1;
        state    <= IDLE;
      end
    end
  end

endmodule

// File: tb/tb_nec_ir_decoder.sv
// tb/tb_nec_ir_decoder.sv - directed self-checking bench for nec_ir_decoder
`timescale 1ns/1ps
module tb_nec_ir_decoder;

  localparam int TK = 8;

  logic        clkIN = 1'b0;
  logic        nResetIN;
  logic        rxIN;
  logic        dataValidOUT, repeatOUT, errorOUT;
  logic [31:0] dataOUT;
  logic [15:0] addressOUT;
  logic [7:0]  commandOUT, repeatCountOUT;

  int total = 0;
  int bad = 0;
  int dvCnt = 0, rptCnt = 0, errCnt = 0;
  int dv0, rp0, er0;

  always #10 clkIN = ~clkIN;

  nec_ir_decoder #(
    .CLOCK_HZ     (7111 * TK),
    .RX_ACTIVE_LOW(1),
    .FILTER_CYCLES(8),
    .EXTENDED_ADDR(0),
    .REPEAT_WINDOW(800)
  ) dut (
    .clkIN         (clkIN),
    .nResetIN      (nResetIN),
    .rxIN          (rxIN),
    .dataValidOUT  (dataValidOUT),
    .repeatOUT     (repeatOUT),
    .errorOUT      (errorOUT),
    .dataOUT       (dataOUT),
    .addressOUT    (addressOUT),
    .commandOUT    (commandOUT),
    .repeatCountOUT(repeatCountOUT)
  );

  always @(posedge clkIN) begin
    #1;
    if (dataValidOUT) dvCnt++;
    if (repeatOUT) rptCnt++;
    if (errorOUT) errCnt++;
  end

  task automatic hold(input logic level, input int ticks);
    rxIN = level;
    repeat (ticks * TK) @(negedge clkIN);
  endtask

  task automatic sendBits(input logic [31:0] d, input int n);
    for (int i = 0; i < n; i++) begin
      hold(1'b0, 4);
      hold(1'b1, d[i] ? 12 : 4);
    end
  endtask

  task automatic sendFrame(input logic [31:0] d);
    hold(1'b0, 64);
    hold(1'b1, 32);
    sendBits(d, 32);
    hold(1'b0, 4);
    hold(1'b1, 20);
  endtask

  task automatic sendRepeat();
    hold(1'b0, 64);
    hold(1'b1, 16);
    hold(1'b0, 4);
    hold(1'b1, 20);
  endtask

  task automatic snap();
    dv0 = dvCnt;
    rp0 = rptCnt;
    er0 = errCnt;
  endtask

  task automatic test_reset();
    rxIN = 1'b1;
    nResetIN = 1'b0;
    repeat (5) @(negedge clkIN);
    total++;
    if ({dataValidOUT, repeatOUT, errorOUT} !== 3'b000) begin
      bad++; $display("FAIL reset_pulses: got %b want 000", {dataValidOUT, repeatOUT, errorOUT});
    end
    total++;
    if (dataOUT !== 32'h0) begin
      bad++; $display("FAIL reset_data: got %h want 00000000", dataOUT);
    end
    total++;
    if ({addressOUT, commandOUT, repeatCountOUT} !== 32'h0) begin
      bad++; $display("FAIL reset_fields: got %h want 00000000", {addressOUT, commandOUT, repeatCountOUT});
    end
    nResetIN = 1'b1;
    repeat (5) @(negedge clkIN);
  endtask

  task automatic test_repeat_no_frame();
    snap();
    hold(1'b1, 10);
    sendRepeat();
    total++;
    if (errCnt - er0 !== 1) begin
      bad++; $display("FAIL norpt_error: got %0d want 1", errCnt - er0);
    end
    total++;
    if (rptCnt - rp0 !== 0) begin
      bad++; $display("FAIL norpt_repeat: got %0d want 0", rptCnt - rp0);
    end
  endtask

  task automatic test_frame();
    snap();
    sendFrame(32'hF708FB04);
    total++;
    if (dvCnt - dv0 !== 1) begin
      bad++; $display("FAIL frame_valid: got %0d want 1", dvCnt - dv0);
    end
    total++;
    if (errCnt - er0 !== 0) begin
      bad++; $display("FAIL frame_error: got %0d want 0", errCnt - er0);
    end
    total++;
    if (dataOUT !== 32'hF708FB04) begin
      bad++; $display("FAIL frame_data: got %h want f708fb04", dataOUT);
    end
    total++;
    if (addressOUT !== 16'h0004) begin
      bad++; $display("FAIL frame_addr: got %h want 0004", addressOUT);
    end
    total++;
    if (commandOUT !== 8'h08) begin
      bad++; $display("FAIL frame_cmd: got %h want 08", commandOUT);
    end
    total++;
    if (repeatCountOUT !== 8'd0) begin
      bad++; $display("FAIL frame_rptcnt: got %0d want 0", repeatCountOUT);
    end
  endtask

  task automatic test_repeat();
    snap();
    for (int i = 0; i < 3; i++) begin
      hold(1'b1, 200);
      sendRepeat();
    end
    total++;
    if (rptCnt - rp0 !== 3) begin
      bad++; $display("FAIL repeat_pulses: got %0d want 3", rptCnt - rp0);
    end
    total++;
    if (repeatCountOUT !== 8'd3) begin
      bad++; $display("FAIL repeat_count: got %0d want 3", repeatCountOUT);
    end
    total++;
    if (errCnt - er0 !== 0) begin
      bad++; $display("FAIL repeat_error: got %0d want 0", errCnt - er0);
    end
    total++;
    if (dataOUT !== 32'hF708FB04) begin
      bad++; $display("FAIL repeat_data: got %h want f708fb04", dataOUT);
    end
  endtask

  task automatic test_window_expired();
    snap();
    hold(1'b1, 900);
    sendRepeat();
    total++;
    if (errCnt - er0 !== 1) begin
      bad++; $display("FAIL expired_error: got %0d want 1", errCnt - er0);
    end
    total++;
    if (rptCnt - rp0 !== 0) begin
      bad++; $display("FAIL expired_repeat: got %0d want 0", rptCnt - rp0);
    end
    total++;
    if (repeatCountOUT !== 8'd3) begin
      bad++; $display("FAIL expired_count: got %0d want 3", repeatCountOUT);
    end
  endtask

  task automatic test_short_leader();
    snap();
    hold(1'b0, 42);
    hold(1'b1, 40);
    total++;
    if (errCnt - er0 !== 1) begin
      bad++; $display("FAIL short_error: got %0d want 1", errCnt - er0);
    end
    total++;
    if (dvCnt - dv0 !== 0) begin
      bad++; $display("FAIL short_valid: got %0d want 0", dvCnt - dv0);
    end
    total++;
    if (dataOUT !== 32'hF708FB04) begin
      bad++; $display("FAIL short_data: got %h want f708fb04", dataOUT);
    end
  endtask

  task automatic test_timeout();
    snap();
    hold(1'b0, 64);
    hold(1'b1, 300);
    total++;
    if (errCnt - er0 !== 1) begin
      bad++; $display("FAIL timeout_error: got %0d want 1", errCnt - er0);
    end
    total++;
    if (dvCnt - dv0 + rptCnt - rp0 !== 0) begin
      bad++; $display("FAIL timeout_pulses: got %0d want 0", dvCnt - dv0 + rptCnt - rp0);
    end
  endtask

  task automatic test_integrity();
    snap();
    sendFrame(32'hF608FB04);
`ifdef NEC_IR_STRICT_CHECK_EN
    total++;
    if (errCnt - er0 !== 1) begin
      bad++; $display("FAIL strict_error: got %0d want 1", errCnt - er0);
    end
    total++;
    if (dvCnt - dv0 !== 0) begin
      bad++; $display("FAIL strict_valid: got %0d want 0", dvCnt - dv0);
    end
    total++;
    if (dataOUT !== 32'hF708FB04) begin
      bad++; $display("FAIL strict_data: got %h want f708fb04", dataOUT);
    end
`else
    total++;
    if (dvCnt - dv0 !== 1) begin
      bad++; $display("FAIL loose_valid: got %0d want 1", dvCnt - dv0);
    end
    total++;
    if (dataOUT !== 32'hF608FB04) begin
      bad++; $display("FAIL loose_data: got %h want f608fb04", dataOUT);
    end
    total++;
    if (repeatCountOUT !== 8'd0) begin
      bad++; $display("FAIL loose_rptcnt: got %0d want 0", repeatCountOUT);
    end
`endif
  endtask

  task automatic test_glitch_reset();
    snap();
    for (int i = 0; i < 5; i++) begin
      rxIN = 1'b0;
      repeat (5) @(negedge clkIN);
      rxIN = 1'b1;
      repeat (50) @(negedge clkIN);
    end
    total++;
    if (dvCnt - dv0 + rptCnt - rp0 + errCnt - er0 !== 0) begin
      bad++; $display("FAIL glitch_pulses: got %0d want 0", dvCnt - dv0 + rptCnt - rp0 + errCnt - er0);
    end
    hold(1'b0, 64);
    hold(1'b1, 32);
    sendBits(32'hF708FB04, 20);
    rxIN = 1'b0;
    repeat (2 * TK) @(negedge clkIN);
    nResetIN = 1'b0;
    rxIN = 1'b1;
    repeat (4) @(negedge clkIN);
    total++;
    if (dataOUT !== 32'h0) begin
      bad++; $display("FAIL midreset_data: got %h want 00000000", dataOUT);
    end
    total++;
    if (repeatCountOUT !== 8'd0) begin
      bad++; $display("FAIL midreset_rptcnt: got %0d want 0", repeatCountOUT);
    end
    nResetIN = 1'b1;
    hold(1'b1, 40);
    total++;
    if (dvCnt - dv0 + rptCnt - rp0 + errCnt - er0 !== 0) begin
      bad++; $display("FAIL midreset_pulses: got %0d want 0", dvCnt - dv0 + rptCnt - rp0 + errCnt - er0);
    end
  endtask

  initial begin
    rxIN = 1'b1;
    nResetIN = 1'b0;
    @(negedge clkIN);
    test_reset();
    test_repeat_no_frame();
    test_frame();
    test_repeat();
    test_window_expired();
    test_short_leader();
    test_timeout();
    test_integrity();
    test_glitch_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
